// File: rtl/serial_add_arb_if.sv
// Request/operand and result/ack bundle shared between the two requesters
// and the bit-serial adder controller.
interface serial_add_arb_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             owner;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  ack0, ack1, busy, owner, sum, cout
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output ack0, ack1, busy, owner, sum, cout
    );
endinterface

// File: rtl/serial_add_arb.sv
// Bit-serial adder shared by two round-robin arbitrated requesters:
// one full-adder cell stepped LSB first over WIDTH cycles per operation.
module serial_add_arb #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_arb_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             grant;
    logic             bit_a, bit_b, bit_s, bit_c;

    // On a tie the requester that did not win last time gets the cell.
    assign grant = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    assign bit_a = a_q[cnt_q];
    assign bit_b = b_q[cnt_q];
    assign bit_s = bit_a ^ bit_b ^ carry_q;
    assign bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    a_d     = grant ? bus.a1 : bus.a0;
                    b_d     = grant ? bus.b1 : bus.b0;
                    owner_d = grant;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[cnt_q] = bit_s;
                carry_d      = bit_c;
                cnt_d        = cnt_q + 1'b1;
                // Partial sums stay internal; the visible result changes only here.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack0  = (state_q == DONE) && !owner_q;
    assign bus.ack1  = (state_q == DONE) && owner_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.owner = owner_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule
